// File: rtl/qdr_ui_pkg.sv
// Shared types, default widths and sizing helpers for the QDRII+ UI adapter.
package qdr_ui_pkg;

   typedef enum logic [0:0] {
      CAL_WAIT = 1'b0,
      RUN      = 1'b1
   } ui_state_t;

   localparam int unsigned DEF_ADDR_WIDTH = 18;
   localparam int unsigned DEF_DATA_WIDTH = 36;
   localparam int unsigned DEF_BW_WIDTH   = 4;
   localparam int unsigned DEF_TAG_WIDTH  = 4;
   localparam int unsigned DEF_RSP_DEPTH  = 16;

   // Credit counter must hold the value DEPTH itself, hence one extra bit.
   function automatic int unsigned credit_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/qdr_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word reads as zero when empty.
module qdr_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign dout    = (count == '0) ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since the count gates the head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/qdr_ui_adapter.sv
// Request-stream front end for the QDRII+ controller port-0 user interface:
// issues burst-of-4 commands in order and returns tagged read data with
// credit-based flow control on the response path.
module qdr_ui_adapter
   import qdr_ui_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned BW_WIDTH   = DEF_BW_WIDTH,
   parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int unsigned RSP_DEPTH  = DEF_RSP_DEPTH
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     cal_done,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   input  logic [4*DATA_WIDTH-1:0]  req_data,
   input  logic [4*BW_WIDTH-1:0]    req_bw_n,
   input  logic [TAG_WIDTH-1:0]     req_tag,
   output logic                     app_wr_cmd0,
   output logic                     app_rd_cmd0,
   output logic [ADDR_WIDTH-1:0]    app_wr_addr0,
   output logic [ADDR_WIDTH-1:0]    app_rd_addr0,
   output logic [4*DATA_WIDTH-1:0]  app_wr_data0,
   output logic [4*BW_WIDTH-1:0]    app_wr_bw_n0,
   input  logic                     app_rd_valid0,
   input  logic [4*DATA_WIDTH-1:0]  app_rd_data0,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [4*DATA_WIDTH-1:0]  rsp_data,
   output logic [TAG_WIDTH-1:0]     rsp_tag,
   output logic                     rd_unexpected
);

   localparam int unsigned CW = credit_width(RSP_DEPTH);
   localparam int unsigned RW = 4*DATA_WIDTH + TAG_WIDTH;

   ui_state_t                 state;
   ui_state_t                 state_nxt;
   logic [CW-1:0]             credit;
   logic                      wr_accept;
   logic                      rd_accept;
   logic                      rd_ret_ok;
   logic                      rsp_pop;
   logic [TAG_WIDTH-1:0]      ret_tag;
   logic [$clog2(RSP_DEPTH):0] tag_count;
   logic [$clog2(RSP_DEPTH):0] rsp_count;
   logic [RW-1:0]             rsp_word;

   assign wr_accept = req_valid && req_ready && req_we;
   assign rd_accept = req_valid && req_ready && !req_we;
   assign rd_ret_ok = app_rd_valid0 && (tag_count != '0);
   assign rsp_valid = (rsp_count != '0);
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign rsp_data  = rsp_word[TAG_WIDTH +: 4*DATA_WIDTH];
   assign rsp_tag   = rsp_word[TAG_WIDTH-1:0];

   // Calibration state register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= CAL_WAIT;
      else         state <= state_nxt;
   end

   // Next-state and request acceptance; ready ignores valid/we so writes also stall at zero credit.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      case (state)
         CAL_WAIT: if (cal_done) state_nxt = RUN;
         RUN: begin
            req_ready = (credit != '0);
            if (!cal_done) state_nxt = CAL_WAIT;
         end
         default:  state_nxt = CAL_WAIT;
      endcase
   end

   // Command registers, response credit and the sticky unexpected-return flag.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         app_wr_cmd0   <= 1'b0;
         app_rd_cmd0   <= 1'b0;
         app_wr_addr0  <= '0;
         app_rd_addr0  <= '0;
         app_wr_data0  <= '0;
         app_wr_bw_n0  <= '1;
         rd_unexpected <= 1'b0;
         credit        <= CW'(RSP_DEPTH);
      end else begin
         app_wr_cmd0 <= wr_accept;
         app_rd_cmd0 <= rd_accept;
         if (wr_accept) begin
            app_wr_addr0 <= req_addr;
            app_wr_data0 <= req_data;
            app_wr_bw_n0 <= req_bw_n;
         end
         if (rd_accept) app_rd_addr0 <= req_addr;
         if (app_rd_valid0 && (tag_count == '0)) rd_unexpected <= 1'b1;
         case ({rd_accept, rsp_pop})
            2'b10:   credit <= credit - CW'(1);
            2'b01:   credit <= credit + CW'(1);
            default: credit <= credit;
         endcase
      end
   end

   qdr_sync_fifo #(
      .WIDTH (TAG_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_tag_q (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .push  (rd_accept),
      .din   (req_tag),
      .pop   (rd_ret_ok),
      .dout  (ret_tag),
      .count (tag_count)
   );

   qdr_sync_fifo #(
      .WIDTH (RW),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_q (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .push  (rd_ret_ok),
      .din   ({app_rd_data0, ret_tag}),
      .pop   (rsp_pop),
      .dout  (rsp_word),
      .count (rsp_count)
   );

endmodule

// File: tb/tb_qdr_ui_adapter.sv
// Directed self-checking bench for qdr_ui_adapter (default parameters).
module tb_qdr_ui_adapter;

   localparam int unsigned AW = 18;
   localparam int unsigned DW = 144;
   localparam int unsigned BW = 16;
   localparam int unsigned TW = 4;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          cal_done;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic [BW-1:0] req_bw_n;
   logic [TW-1:0] req_tag;
   logic          app_wr_cmd0;
   logic          app_rd_cmd0;
   logic [AW-1:0] app_wr_addr0;
   logic [AW-1:0] app_rd_addr0;
   logic [DW-1:0] app_wr_data0;
   logic [BW-1:0] app_wr_bw_n0;
   logic          app_rd_valid0;
   logic [DW-1:0] app_rd_data0;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [TW-1:0] rsp_tag;
   logic          rd_unexpected;

   int n_cmp = 0;
   int n_err = 0;
   int n_rd;

   logic [DW-1:0] wdata;
   logic [DW-1:0] d1, d2, d3, d4;

   always #5 sys_clk = ~sys_clk;

   qdr_ui_adapter #(
      .ADDR_WIDTH (18),
      .DATA_WIDTH (36),
      .BW_WIDTH   (4),
      .TAG_WIDTH  (4),
      .RSP_DEPTH  (16)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .cal_done      (cal_done),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_bw_n      (req_bw_n),
      .req_tag       (req_tag),
      .app_wr_cmd0   (app_wr_cmd0),
      .app_rd_cmd0   (app_rd_cmd0),
      .app_wr_addr0  (app_wr_addr0),
      .app_rd_addr0  (app_rd_addr0),
      .app_wr_data0  (app_wr_data0),
      .app_wr_bw_n0  (app_wr_bw_n0),
      .app_rd_valid0 (app_rd_valid0),
      .app_rd_data0  (app_rd_data0),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_tag       (rsp_tag),
      .rd_unexpected (rd_unexpected)
   );

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks every output against its reset value, plus the internal credit.
   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_req_ready"}, req_ready, 0);
      chk({pfx, "_wr_cmd"}, app_wr_cmd0, 0);
      chk({pfx, "_rd_cmd"}, app_rd_cmd0, 0);
      chk({pfx, "_wr_addr"}, app_wr_addr0, 0);
      chk({pfx, "_rd_addr"}, app_rd_addr0, 0);
      chk({pfx, "_wr_data"}, app_wr_data0, 0);
      chk({pfx, "_wr_bw_n"}, app_wr_bw_n0, 16'hFFFF);
      chk({pfx, "_rsp_valid"}, rsp_valid, 0);
      chk({pfx, "_rsp_data"}, rsp_data, 0);
      chk({pfx, "_rsp_tag"}, rsp_tag, 0);
      chk({pfx, "_rd_unexp"}, rd_unexpected, 0);
      chk({pfx, "_credit"}, dut.credit, 16);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit (observed timeout, required finish)");
      $fatal(1, "watchdog");
   end

   initial begin
      wdata = {18{8'hA5}};
      d1 = {4{36'h1_1111_1111}};
      d2 = {4{36'h2_2222_2222}};
      d3 = {4{36'h3_3333_3333}};
      d4 = {4{36'h4_4444_4444}};

      sys_rst = 1'b1; cal_done = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_data = '0; req_bw_n = '0; req_tag = '0;
      app_rd_valid0 = 1'b0; app_rd_data0 = '0; rsp_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge sys_clk);
      chk_reset_values("rst");
      sys_rst = 1'b0;

      // Calibration gating: requests pending but nothing accepted
      req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge sys_clk);
         chk("cal_gate", {req_ready, app_wr_cmd0, app_rd_cmd0}, 0);
      end
      req_valid = 1'b0;
      cal_done  = 1'b1;
      @(negedge sys_clk);
      chk("ready_after_cal", req_ready, 1);

      // Single write
      req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00010; req_data = wdata; req_bw_n = '0;
      @(negedge sys_clk);
      req_valid = 1'b0;
      chk("wr_cmd", app_wr_cmd0, 1);
      chk("wr_addr", app_wr_addr0, 18'h00010);
      chk("wr_data", app_wr_data0, wdata);
      chk("wr_bw_n", app_wr_bw_n0, 0);
      chk("wr_no_rd", app_rd_cmd0, 0);
      @(negedge sys_clk);
      chk("wr_cmd_pulse", app_wr_cmd0, 0);
      chk("wr_addr_hold", app_wr_addr0, 18'h00010);

      // Three in-order reads
      rsp_ready = 1'b1; req_we = 1'b0;
      req_valid = 1'b1; req_addr = 18'h1; req_tag = 4'd3;
      @(negedge sys_clk);
      chk("rd1_cmd", {app_rd_cmd0, app_rd_addr0}, {1'b1, 18'h1});
      req_addr = 18'h2; req_tag = 4'd7;
      @(negedge sys_clk);
      chk("rd2_cmd", {app_rd_cmd0, app_rd_addr0}, {1'b1, 18'h2});
      req_addr = 18'h3; req_tag = 4'd9;
      @(negedge sys_clk);
      chk("rd3_cmd", {app_rd_cmd0, app_rd_addr0}, {1'b1, 18'h3});
      req_valid = 1'b0;
      @(negedge sys_clk);
      chk("rd_cmd_idle", app_rd_cmd0, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         chk("rsp_idle", rsp_valid, 0);
      end
      app_rd_valid0 = 1'b1; app_rd_data0 = d1;
      @(negedge sys_clk);
      chk("rsp1", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd3, d1});
      app_rd_data0 = d2;
      @(negedge sys_clk);
      chk("rsp2", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd7, d2});
      app_rd_data0 = d3;
      @(negedge sys_clk);
      chk("rsp3", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd9, d3});
      app_rd_valid0 = 1'b0;
      @(negedge sys_clk);
      chk("rsp_drained", rsp_valid, 0);
      chk("credit_restored", dut.credit, 16);

      // Credit exhaustion: 20 reads offered, no response pops
      rsp_ready = 1'b0; n_rd = 0;
      for (int i = 0; i < 22; i++) begin
         if (i < 20) begin
            req_valid = 1'b1; req_addr = AW'(32'h100 + i); req_tag = TW'(i);
         end else begin
            req_valid = 1'b0;
         end
         @(negedge sys_clk);
         if (app_rd_cmd0) n_rd++;
      end
      req_valid = 1'b0;
      chk("exhaust_count", n_rd, 16);
      chk("exhaust_ready", req_ready, 0);
      chk("exhaust_credit", dut.credit, 0);
      for (int i = 0; i < 16; i++) begin
         app_rd_valid0 = 1'b1; app_rd_data0 = {4{36'(i)}};
         @(negedge sys_clk);
      end
      app_rd_valid0 = 1'b0;
      @(negedge sys_clk);
      chk("full_head", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd0, {4{36'd0}}});
      chk("full_ready", req_ready, 0);
      rsp_ready = 1'b1;
      @(negedge sys_clk);
      rsp_ready = 1'b0;
      chk("pop_ready", req_ready, 1);
      chk("pop_next_head", {rsp_tag, rsp_data}, {4'd1, {4{36'd1}}});
      req_valid = 1'b1; req_addr = 18'h200; req_tag = 4'hC;
      @(negedge sys_clk);
      chk("one_more_cmd", {app_rd_cmd0, app_rd_addr0}, {1'b1, 18'h200});
      chk("one_more_ready", req_ready, 0);
      @(negedge sys_clk);
      chk("no_second_cmd", app_rd_cmd0, 0);
      req_valid = 1'b0;
      app_rd_valid0 = 1'b1; app_rd_data0 = d4;
      @(negedge sys_clk);
      app_rd_valid0 = 1'b0; rsp_ready = 1'b1;
      repeat (20) @(negedge sys_clk);
      rsp_ready = 1'b0;
      chk("drain_empty", rsp_valid, 0);
      chk("drain_credit", dut.credit, 16);
      chk("drain_no_unexp", rd_unexpected, 0);

      // Unexpected return with nothing outstanding
      app_rd_valid0 = 1'b1; app_rd_data0 = d1;
      @(negedge sys_clk);
      app_rd_valid0 = 1'b0;
      chk("unexp_flag", rd_unexpected, 1);
      chk("unexp_no_rsp", rsp_valid, 0);
      chk("unexp_credit", dut.credit, 16);
      @(negedge sys_clk);
      chk("unexp_sticky", {rd_unexpected, rsp_valid}, 2'b10);

      // Reset mid-flight: 5 reads issued, 2 returned and buffered
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(32'h300 + i); req_tag = TW'(i);
         @(negedge sys_clk);
      end
      req_valid = 1'b0;
      app_rd_valid0 = 1'b1; app_rd_data0 = d2;
      @(negedge sys_clk);
      app_rd_data0 = d3;
      @(negedge sys_clk);
      app_rd_valid0 = 1'b0;
      @(negedge sys_clk);
      chk("pre_rst_head", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 4'd0, d2});
      chk("pre_rst_credit", dut.credit, 11);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      chk_reset_values("midrst");
      @(negedge sys_clk);
      chk("midrst_ready", req_ready, 1);
      app_rd_valid0 = 1'b1; app_rd_data0 = d4;
      @(negedge sys_clk);
      app_rd_valid0 = 1'b0;
      chk("late_unexp", rd_unexpected, 1);
      chk("late_no_rsp", rsp_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/qdr_ui_adapter.md
# qdr_ui_adapter

Request-stream front end for the QDRII+ memory controller user interface. Accepts in-order read/write requests from a client over a valid/ready port, issues single-cycle burst-of-4 commands to the controller's port-0 write and read channels, and returns tagged read data through a response FIFO. Credit-based flow control keeps the response path from overflowing, since the controller cannot be back-pressured. Sits between client logic and the controller instance, in the controller user clock domain, gated by `cal_done`.

## Interface
- `ADDR_WIDTH`, 18: QDR burst address width.
- `DATA_WIDTH`, 36: QDR data-pin width; user data is `4*DATA_WIDTH`.
- `BW_WIDTH`, 4: byte-write lanes per beat; user mask is `4*BW_WIDTH`.
- `TAG_WIDTH`, 4: client read tag.
- `RSP_DEPTH`, 16: response FIFO depth, power of 2, maximum reads in flight plus buffered.

Ports:
- `sys_clk` in 1: controller user clock; the only clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `cal_done` in 1: controller calibration complete.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 for write, 0 for read.
- `req_addr` in ADDR_WIDTH: burst address.
- `req_data` in 4*DATA_WIDTH: write data.
- `req_bw_n` in 4*BW_WIDTH: active-low byte mask.
- `req_tag` in TAG_WIDTH: read tag.
- `app_wr_cmd0`, `app_rd_cmd0` out 1: command strobes.
- `app_wr_addr0`, `app_rd_addr0` out ADDR_WIDTH: command addresses.
- `app_wr_data0` out 4*DATA_WIDTH; `app_wr_bw_n0` out 4*BW_WIDTH: write payload.
- `app_rd_valid0` in 1; `app_rd_data0` in 4*DATA_WIDTH: controller read return.
- `rsp_valid` out 1; `rsp_ready` in 1; `rsp_data` out 4*DATA_WIDTH; `rsp_tag` out TAG_WIDTH: response stream.
- `rd_unexpected` out 1: sticky error flag.

## Operation
- FSM states:
  - `CAL_WAIT` is the reset state. It moves to `RUN` on the first cycle `cal_done`=1.
  - `RUN` returns to `CAL_WAIT` if `cal_done` drops.
  - Reads already in flight still complete, and their data is still captured.
- `req_ready` = (state==`RUN`) && (credit != 0). It does not depend on `req_valid` or `req_we`. Writes also stall at zero credit, which preserves ordering.
- Accepted write:
  - Register addr, data and mask into the `app_wr_*` outputs.
  - Pulse `app_wr_cmd0` for one cycle.
- Accepted read:
  - Register the address into `app_rd_addr0` and pulse `app_rd_cmd0`.
  - Push `req_tag` into the tag queue (depth RSP_DEPTH).
  - Decrement credit.
- Only one command is issued per cycle, strictly in request order.
- `app_rd_valid0`=1:
  - Pop the tag queue.
  - Push {data, tag} into the response FIFO.
  - If the tag queue is empty, drop the data and set `rd_unexpected` (it stays set until reset).
- Response pop (`rsp_valid && rsp_ready`) increments credit. A read issued in the same cycle as a pop leaves credit unchanged.
- Credit counter width is clog2(RSP_DEPTH)+1, initialised to RSP_DEPTH. It never exceeds RSP_DEPTH and never underflows.
- The response FIFO cannot overflow: occupancy + reads in flight ≤ RSP_DEPTH by construction.

## Timing
- Reset values:
  - `req_ready`, `app_wr_cmd0`, `app_rd_cmd0`, `rsp_valid`, `rd_unexpected` = 0.
  - All address/data/mask/tag outputs = 0, except `app_wr_bw_n0` = all ones.
  - Credit = RSP_DEPTH; FIFOs empty; state `CAL_WAIT`.
- `sys_rst` mid-operation:
  - Discards queued tags and responses and restores credit.
  - Read data returned after reset sets `rd_unexpected`.
- Request-to-command latency is 1 cycle. The command strobe is asserted exactly one cycle per accepted request.
- `app_*` data outputs hold their last value when the strobe is 0.
- `app_rd_valid0`-to-`rsp_valid` latency is 1 cycle when the FIFO is empty.
- `rsp_*` outputs hold stable while `rsp_valid && !rsp_ready`.
- Sustained throughput is 1 request per cycle while credit > 0.

## Structure
- Shared package `qdr_ui_pkg`: FSM state encoding (`CAL_WAIT`, `RUN`), default widths, and a credit-width function.
- One sub-module, `qdr_sync_fifo`, a parameterised synchronous FIFO (width, depth, count output). It is instantiated twice: once as the tag queue and once as the response FIFO.

## Test plan
- Calibration gating: hold `cal_done`=0 for 50 cycles with `req_valid`=1.
  - `req_ready`=0 and no command strobes throughout.
  - Raise `cal_done`: `req_ready`=1 on the next cycle.
- Write: write to addr 0x00010 with data pattern 0xA5… and bw_n=0x0000.
  - `app_wr_cmd0` pulses one cycle later with matching addr/data/mask.
  - `app_rd_cmd0` stays 0.
- Reads in order: issue reads to 0x1, 0x2, 0x3 with tags 3, 7, 9; the controller returns data D1, D2, D3 10 cycles later.
  - Responses arrive in the order (D1,3), (D2,7), (D3,9), each 1 cycle after its `app_rd_valid0`.
- Credit exhaustion: RSP_DEPTH=16, `rsp_ready`=0, issue 20 reads.
  - Exactly 16 are accepted; `req_ready`=0 from then on.
  - Popping one response restores `req_ready` for exactly one more read.
- Unexpected return: pulse `app_rd_valid0` with no reads outstanding.
  - `rd_unexpected`=1; `rsp_valid` stays 0; credit stays 16.
- Reset mid-flight: 5 reads outstanding, assert `sys_rst` for one cycle.
  - All outputs return to their reset values; credit=16.
  - A late `app_rd_valid0` sets `rd_unexpected`.
